dequantize_row_streamer: RTL
============================

# dequantize_row_streamer

Widens a Q2.14 (16-bit) matrix back to Q18.14 (32-bit) and streams it out one row per transfer under valid/ready flow control. It is the return path of the attention datapath: softmax/probability matrices leave the 16-bit domain here and re-enter the systolic array for the P×V multiply. Each element is sign-extended and multiplied by 2^SHIFT, which by default undoes the 1/8 score scaling. Whole-matrix handoff happens on the input side; row-serial delivery happens on the output side.

## Interface
- ROWS, 32, matrix rows and number of output transfers per matrix
- COLS, 32, matrix columns, i.e. elements per output row
- INPUT_BIT_WIDTH, 16, input element width, Q2.14
- OUTPUT_BIT_WIDTH, 32, output element width, Q18.14
- SHIFT, 3, left-shift gain applied after sign extension; legal range 0..24
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  i_matrix is valid
- o_ready  out  1  block can accept a matrix
- i_matrix  in  ROWS×COLS×INPUT_BIT_WIDTH (signed, packed [r][c])  input matrix
- o_valid  out  1  o_row is valid
- i_ready  in  1  downstream accepts o_row
- o_row  out  COLS×OUTPUT_BIT_WIDTH (signed, packed [c])  current converted row
- o_row_idx  out  $clog2(ROWS)  index of the row on o_row
- o_last  out  1  o_row is row ROWS-1

## Operation
- FSM has two states:
  - IDLE: o_ready=1, o_valid=0.
  - STREAM: o_ready=0, o_valid=1.
- IDLE to STREAM on i_valid && o_ready.
  - The full i_matrix is captured into an internal ROWS×COLS×16 buffer.
  - o_row is loaded with converted row 0, and o_row_idx=0.
- In STREAM, a transfer is o_valid && i_ready.
  - On a transfer with idx<ROWS-1: idx increments and o_row loads converted row idx+1.
  - On a transfer with idx==ROWS-1: go to IDLE.
- While o_valid && !i_ready, o_row, o_row_idx and o_last are held bit-stable.
- o_last = (state==STREAM) && (o_row_idx==ROWS-1).
- i_valid while in STREAM is ignored; no capture occurs.
- Conversion per element: y = sign_extend(x, OUTPUT_BIT_WIDTH) <<< SHIFT.
  - Fraction bits are unchanged (14), so SHIFT is a pure gain.
  - The overflow path is evaluated at INPUT_BIT_WIDTH+SHIFT bits, then reduced to OUTPUT_BIT_WIDTH per Configuration.
- Reset values: o_valid=0, o_ready=1 (IDLE), o_row=0, o_row_idx=0, o_last=0, buffer=0.
- Reset asserted mid-stream aborts the matrix. After reset releases, the FSM is in IDLE with no residual rows.

## Timing
- All outputs are registered. There is no combinational path from i_valid, i_matrix or i_ready to any output.
- Latency: capture at edge N gives o_valid=1 with row 0 after edge N.
- With i_ready held high, rows 0..ROWS-1 occupy ROWS consecutive cycles.
- o_ready returns high the cycle after the last transfer.
- Minimum matrix period is ROWS+1 cycles.
- i_ready may toggle arbitrarily; each row is delivered exactly once, in order.

## Configuration
- DEQUANT_SAT_EN defined:
  - Results above 2^(OUTPUT_BIT_WIDTH-1)-1 clamp to 32'h7FFF_FFFF.
  - Results below -2^(OUTPUT_BIT_WIDTH-1) clamp to 32'h8000_0000.
- DEQUANT_SAT_EN undefined: results wrap, keeping the low OUTPUT_BIT_WIDTH bits.
- For SHIFT≤16 with the default widths, both builds are bit-identical.

## Structure
- Package dequant_pkg holds:
  - the FSM state enum typedef (ST_IDLE, ST_STREAM);
  - Q-format constants FRAC_BITS=14, IN_W=16, OUT_W=32.
- Sub-module dequant_elem: one signed element, sign-extend, shift, saturate/wrap under the macro. It is purely combinational and instantiated COLS times on the selected buffer row.
- Top level holds the FSM, row counter, buffer and output registers.

## Test plan
- Basic conversion (defaults): all elements 16'h4000 (+1.0) gives every o_row element 32'h0002_0000. Element 16'h8000 gives 32'hFFFC_0000.
- Full stream: i_ready=1 and matrix element (r,c)=r*COLS+c gives 32 consecutive rows in order. o_row_idx runs 0..31 and o_last is high only on idx 31. o_ready rises exactly 1 cycle after the last transfer.
- Backpressure: i_ready low for 3 cycles while idx=5. o_row, o_row_idx and o_last stay stable, then row 5 is delivered once and row 6 follows. No row is dropped or duplicated.
- Overflow, SHIFT=20: input 16'h7FFF gives 32'h7FFF_FFFF with DEQUANT_SAT_EN and 32'hFFF0_0000 without it. Input 16'h8000 gives 32'h8000_0000 with the macro and 32'h0000_0000 without it.
- Ignored input: i_valid pulsed with a different matrix during STREAM. Output rows all come from the first matrix.
- Reset mid-stream: i_rst asserted at idx=10 gives o_valid=0, o_row=0 and o_ready=1 immediately. A new matrix captured after release streams from row 0.

Source files
------------

// File: rtl/dequant_pkg.sv
// Shared types and Q-format constants for the dequantize row streamer.
//
// Contents:
//   FRAC_BITS  fraction bits carried by both the Q2.14 and Q18.14 formats
//   IN_W       narrow element width (Q2.14)
//   OUT_W      wide element width (Q18.14)
//   state_e    streamer FSM state encoding
package dequant_pkg;

  localparam int FRAC_BITS = 14;
  localparam int IN_W      = 16;
  localparam int OUT_W     = 32;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/dequant_elem.sv
// Single-element widener: sign-extend a narrow signed value, apply a fixed
// left-shift gain, then reduce to the output width.
//
// Build option: define DEQUANT_SAT_EN to clamp out-of-range results to the
// most positive / most negative output code; otherwise the result wraps to
// the low OUT_BITS bits.
//
// Ports:
//   i_x  in   IN_BITS   signed input element
//   o_y  out  OUT_BITS  signed widened, scaled element
//
// Purely combinational.
module dequant_elem
  import dequant_pkg::*;
#(
  parameter int IN_BITS  = IN_W,
  parameter int OUT_BITS = OUT_W,
  parameter int SHIFT    = 3
) (
  input  logic signed [IN_BITS-1:0]  i_x,
  output logic signed [OUT_BITS-1:0] o_y
);

  // The product is exact at IN_BITS+SHIFT bits; never evaluate narrower than
  // the output so small shifts need no reduction step at all.
  localparam int EXT_W  = IN_BITS + SHIFT;
  localparam int WIDE_W = (EXT_W > OUT_BITS) ? EXT_W : OUT_BITS;

  logic signed [WIDE_W-1:0] wide;

  assign wide = WIDE_W'(i_x) <<< SHIFT;

  generate
    if (WIDE_W == OUT_BITS) begin : g_fits
      assign o_y = wide;
    end else begin : g_reduce
`ifdef DEQUANT_SAT_EN
      // In range only if every bit from the output sign bit upward agrees.
      logic [WIDE_W-OUT_BITS:0] top_bits;
      logic                     ovf;

      assign top_bits = wide[WIDE_W-1:OUT_BITS-1];
      assign ovf      = !((&top_bits) || !(|top_bits));
      assign o_y      = !ovf ? wide[OUT_BITS-1:0] :
                        wide[WIDE_W-1] ? {1'b1, {(OUT_BITS-1){1'b0}}} :
                                         {1'b0, {(OUT_BITS-1){1'b1}}};
`else
      // Upper bits are intentionally discarded in the wrapping build.
      logic unused_hi;

      assign unused_hi = ^wide[WIDE_W-1:OUT_BITS];
      assign o_y       = wide[OUT_BITS-1:0];
`endif
    end
  endgenerate

endmodule

// File: rtl/dequantize_row_streamer.sv
// Dequantize row streamer: captures a whole Q2.14 matrix in one handshake and
// returns it row by row as Q18.14 (sign-extended, scaled by 2^SHIFT).
//
// Build option: DEQUANT_SAT_EN (see dequant_elem) selects saturation instead
// of wrap when the scaled value does not fit OUTPUT_BIT_WIDTH.
//
// Ports:
//   i_clk      in   1                    clock
//   i_rst      in   1                    async reset, active high
//   i_valid    in   1                    i_matrix valid
//   o_ready    out  1                    idle, can accept a matrix
//   i_matrix   in   ROWS x COLS x IN     input matrix, packed [r][c]
//   o_valid    out  1                    o_row valid
//   i_ready    in   1                    downstream accepts o_row
//   o_row      out  COLS x OUT           converted row, packed [c]
//   o_row_idx  out  clog2(ROWS)          index of the row on o_row
//   o_last     out  1                    o_row is the final row
//
// FSM:
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | o_ready=1, waiting for i_valid; matrix captured on handshake
//   ST_STREAM | o_valid=1, presenting row o_row_idx until i_ready
module dequantize_row_streamer
  import dequant_pkg::*;
#(
  parameter int ROWS             = 32,
  parameter int COLS             = 32,
  parameter int INPUT_BIT_WIDTH  = IN_W,
  parameter int OUTPUT_BIT_WIDTH = OUT_W,
  parameter int SHIFT            = 3,
  localparam int IDX_W           = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                                              i_clk,
  input  logic                                              i_rst,
  input  logic                                              i_valid,
  output logic                                              o_ready,
  input  logic [ROWS-1:0][COLS-1:0][INPUT_BIT_WIDTH-1:0]    i_matrix,
  output logic                                              o_valid,
  input  logic                                              i_ready,
  output logic [COLS-1:0][OUTPUT_BIT_WIDTH-1:0]             o_row,
  output logic [IDX_W-1:0]                                  o_row_idx,
  output logic                                              o_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  state_e                                         state_q, state_d;
  logic [IDX_W-1:0]                               idx_q, idx_d;
  logic [ROWS-1:0][COLS-1:0][INPUT_BIT_WIDTH-1:0] buf_q, buf_d;
  logic [COLS-1:0][OUTPUT_BIT_WIDTH-1:0]          row_q, row_d;
  logic                                           last_q, last_d;

  logic [IDX_W-1:0]                               next_idx;
  logic [COLS-1:0][INPUT_BIT_WIDTH-1:0]           src_row;
  logic [COLS-1:0][OUTPUT_BIT_WIDTH-1:0]          conv_row;

  assign next_idx = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

  // One converter bank serves both cases: row 0 straight from the input at
  // capture (the buffer is only loaded on that same edge), otherwise the
  // upcoming buffered row.
  assign src_row = (state_q == ST_IDLE) ? i_matrix[0] : buf_q[next_idx];

  generate
    for (genvar c = 0; c < COLS; c++) begin : g_elem
      dequant_elem #(
        .IN_BITS  (INPUT_BIT_WIDTH),
        .OUT_BITS (OUTPUT_BIT_WIDTH),
        .SHIFT    (SHIFT)
      ) u_elem (
        .i_x (src_row[c]),
        .o_y (conv_row[c])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    row_d   = row_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          state_d = ST_STREAM;
          buf_d   = i_matrix;
          idx_d   = '0;
          row_d   = conv_row;
          last_d  = (LAST_IDX == '0);
        end
      end
      ST_STREAM: begin
        if (i_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            last_d  = 1'b0;
          end else begin
            idx_d  = next_idx;
            row_d  = conv_row;
            last_d = (next_idx == LAST_IDX);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      row_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      row_q   <= row_d;
      last_q  <= last_d;
    end
  end

  assign o_ready   = (state_q == ST_IDLE);
  assign o_valid   = (state_q == ST_STREAM);
  assign o_row     = row_q;
  assign o_row_idx = idx_q;
  assign o_last    = last_q;

endmodule
